l2_access_arbiter: RTL and testbench
====================================

# l2_access_arbiter

Round-robin arbiter and sequencer that shares one L2 cache port between two L1-side requesters in the multilevel cache. It grants one requester at a time and holds that requester's cache line vector on the L2 input for a fixed lookup latency. It then captures the L2 data and hit/miss result and returns them to the granted requester with a one-cycle done pulse. It sits between the L1 miss paths and the L2 instance inside the multilevel cache top.

## Interface
- CACHE_TAG_WIDTH, 4, tag field width
- CACHE_DATA_WIDTH, 4, data field width
- OPCODE_WIDTH, 2, opcode field width
- L2_LATENCY, 2, cycles from vector presented to L2 until its response is valid; legal range ≥1
- CACHE_LINE_WIDTH, OPCODE_WIDTH+CACHE_TAG_WIDTH+CACHE_DATA_WIDTH, derived; vector format {opcode, tag, data}; opcode 01 = read, 10 = write, 00/11 = invalid
- Internal latency counter width: `LOG2(L2_LATENCY)+1` from cache_defines.vh

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- rst_n  in  1  synchronous, active-low reset
- req0 / req1  in  1  request from requester 0 / 1; held high until the matching done
- vector0_in / vector1_in  in  CACHE_LINE_WIDTH  request vector, sampled only at the grant edge
- busy0 / busy1  out  1  requester 0 / 1 currently owns L2
- done0 / done1  out  1  one-cycle pulse; result valid on data_out / hit_miss_out
- data_out  out  CACHE_DATA_WIDTH  returned data, held until the next capture
- hit_miss_out  out  1  returned hit (1) or miss (0), held until the next capture
- l2_vector_out  out  CACHE_LINE_WIDTH  vector driven to L2; all zeros (NOP) when not in WAIT
- l2_data_in  in  CACHE_DATA_WIDTH  L2 data output
- l2_hit_miss_in  in  1  L2 hit/miss output

## Operation
- States: IDLE, WAIT, RESPOND.
- IDLE:
  - No request: remain in IDLE.
  - One request: grant that requester.
  - Both requests: grant the requester indicated by the priority pointer.
  - At the grant edge: latch the granted vector, set the matching busy, load counter = L2_LATENCY.
  - Valid opcode: go to WAIT.
  - Invalid opcode: skip L2 and go to RESPOND with data_out = 0 and hit_miss_out = 0.
- WAIT:
  - l2_vector_out = latched vector.
  - Decrement the counter each edge.
  - At the edge where counter == 1: capture l2_data_in / l2_hit_miss_in, go to RESPOND.
- RESPOND:
  - Matching done = 1 for exactly this cycle; busy stays high.
  - Next edge: clear busy, set priority pointer to the other requester, go to IDLE.
- Priority pointer: toggles only after a completed transaction. This includes invalid-opcode transactions, so neither requester can be starved.
- Requester inputs after grant:
  - A req drop or vector change after the grant edge is ignored; the transaction completes and done still pulses.
  - req still high in IDLE after done counts as a new request.
- At most one busy and at most one done are high in any cycle.
- Reset (rst_n low at an edge), from any state including mid-WAIT:
  - state = IDLE, pointer = requester 0, counter = 0
  - busy0/1 = 0, done0/1 = 0
  - data_out = 0, hit_miss_out = 0, l2_vector_out = 0
  - Any in-flight transaction is aborted with no done.

## Timing
- Grant at edge E0 (IDLE sees req):
  - l2_vector_out valid from E0 through edge E0+L2_LATENCY.
  - Capture at edge E0+L2_LATENCY; done high the cycle after it.
  - Return to IDLE at edge E0+L2_LATENCY+1; earliest next grant at edge E0+L2_LATENCY+2.
- Throughput: one transaction per L2_LATENCY+2 cycles.
- Invalid opcode: done high the cycle after the grant edge; 2 cycles per transaction.
- Outputs are registered; no combinational path from req to busy or done.

## Test plan
- Reset, then req0 read {01,1100,1010}; L2 returns data 1010, hit 1 (L2_LATENCY=2):
  - busy0 after grant edge; l2_vector_out = 0111001010 for 2 cycles, then 0.
  - done0 one cycle with data_out = 1010, hit_miss_out = 1.
- req0 and req1 raised in the same cycle and held:
  - Order of done pulses: requester 0 first, then requester 1, then requester 0.
  - Consecutive grants exactly 4 cycles apart.
- req1 read tag 0101, L2 returns miss 0:
  - done1 with hit_miss_out = 0; data_out holds the value until the next capture.
- req0 with opcode 00:
  - No L2 access; l2_vector_out stays 0.
  - done0 the cycle after the grant edge with data_out = 0, hit_miss_out = 0.
- rst_n low during WAIT:
  - Next cycle: all outputs 0, no done.
  - A subsequent req1 with only req1 pending is granted normally.
- req0 dropped one cycle after grant:
  - done0 still pulses at grant+3 cycles.
  - Pointer then favours requester 1.

Source files
------------

// File: rtl/l2_access_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : l2_access_arbiter_if
//  Purpose  : Requester-side and L2-side signal bundle of the L2 access arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface l2_access_arbiter_if #(
    parameter int CACHE_TAG_WIDTH  = 4,
    parameter int CACHE_DATA_WIDTH = 4,
    parameter int OPCODE_WIDTH     = 2
);
    localparam int CACHE_LINE_WIDTH = OPCODE_WIDTH + CACHE_TAG_WIDTH + CACHE_DATA_WIDTH;

    logic                        req0;
    logic                        req1;
    logic [CACHE_LINE_WIDTH-1:0] vector0_in;
    logic [CACHE_LINE_WIDTH-1:0] vector1_in;
    logic                        busy0;
    logic                        busy1;
    logic                        done0;
    logic                        done1;
    logic [CACHE_DATA_WIDTH-1:0] data_out;
    logic                        hit_miss_out;
    logic [CACHE_LINE_WIDTH-1:0] l2_vector_out;
    logic [CACHE_DATA_WIDTH-1:0] l2_data_in;
    logic                        l2_hit_miss_in;

    modport master (
        output req0, req1, vector0_in, vector1_in, l2_data_in, l2_hit_miss_in,
        input  busy0, busy1, done0, done1, data_out, hit_miss_out, l2_vector_out
    );

    modport slave (
        input  req0, req1, vector0_in, vector1_in, l2_data_in, l2_hit_miss_in,
        output busy0, busy1, done0, done1, data_out, hit_miss_out, l2_vector_out
    );
endinterface
`default_nettype wire

// File: rtl/l2_access_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : l2_access_arbiter
//  Purpose  : Round-robin arbiter sharing one L2 port between two L1 requesters.
//  Revision : 1.0  initial release
// ============================================================================
module l2_access_arbiter #(
    parameter int CACHE_TAG_WIDTH  = 4,
    parameter int CACHE_DATA_WIDTH = 4,
    parameter int OPCODE_WIDTH     = 2,
    parameter int L2_LATENCY       = 2
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    l2_access_arbiter_if.slave arb
);
    localparam int CACHE_LINE_WIDTH = OPCODE_WIDTH + CACHE_TAG_WIDTH + CACHE_DATA_WIDTH;
    localparam int c_cnt_w          = $clog2(L2_LATENCY) + 1;

    localparam logic [c_cnt_w-1:0]      c_latency  = c_cnt_w'(L2_LATENCY);
    localparam logic [c_cnt_w-1:0]      c_cnt_one  = c_cnt_w'(1);
    localparam logic [OPCODE_WIDTH-1:0] c_op_read  = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] c_op_write = OPCODE_WIDTH'(2);

    localparam logic [1:0] c_idle    = 2'd0;
    localparam logic [1:0] c_wait    = 2'd1;
    localparam logic [1:0] c_respond = 2'd2;

    logic [1:0]                  r_state;
    logic                        r_ptr;
    logic                        r_gnt;
    logic [c_cnt_w-1:0]          r_cnt;
    logic                        r_busy0;
    logic                        r_busy1;
    logic                        r_done0;
    logic                        r_done1;
    logic [CACHE_DATA_WIDTH-1:0] r_data;
    logic                        r_hit;
    logic [CACHE_LINE_WIDTH-1:0] r_l2_vector;

    logic                        w_gnt1;
    logic [CACHE_LINE_WIDTH-1:0] w_sel_vector;
    logic [OPCODE_WIDTH-1:0]     w_sel_op;
    logic                        w_sel_valid;

    // Pointer only breaks ties; a lone request is always granted.
    assign w_gnt1       = (arb.req0 && arb.req1) ? r_ptr : arb.req1;
    assign w_sel_vector = w_gnt1 ? arb.vector1_in : arb.vector0_in;
    assign w_sel_op     = w_sel_vector[CACHE_LINE_WIDTH-1 -: OPCODE_WIDTH];
    assign w_sel_valid  = (w_sel_op == c_op_read) || (w_sel_op == c_op_write);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_idle;
            r_ptr       <= 1'b0;
            r_gnt       <= 1'b0;
            r_cnt       <= '0;
            r_busy0     <= 1'b0;
            r_busy1     <= 1'b0;
            r_done0     <= 1'b0;
            r_done1     <= 1'b0;
            r_data      <= '0;
            r_hit       <= 1'b0;
            r_l2_vector <= '0;
        end else begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (arb.req0 || arb.req1) begin
                        r_gnt   <= w_gnt1;
                        r_busy0 <= !w_gnt1;
                        r_busy1 <= w_gnt1;
                        r_cnt   <= c_latency;
                        if (w_sel_valid) begin
                            r_l2_vector <= w_sel_vector;
                            r_state     <= c_wait;
                        end else begin
                            // Invalid opcode never reaches L2; answer immediately with a miss.
                            r_data  <= '0;
                            r_hit   <= 1'b0;
                            r_done0 <= !w_gnt1;
                            r_done1 <= w_gnt1;
                            r_state <= c_respond;
                        end
                    end
                end
                c_wait: begin
                    r_cnt <= r_cnt - c_cnt_one;
                    if (r_cnt == c_cnt_one) begin
                        r_data      <= arb.l2_data_in;
                        r_hit       <= arb.l2_hit_miss_in;
                        r_l2_vector <= '0;
                        r_done0     <= !r_gnt;
                        r_done1     <= r_gnt;
                        r_state     <= c_respond;
                    end
                end
                c_respond: begin
                    r_busy0 <= 1'b0;
                    r_busy1 <= 1'b0;
                    r_ptr   <= !r_gnt;
                    r_state <= c_idle;
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign arb.busy0         = r_busy0;
    assign arb.busy1         = r_busy1;
    assign arb.done0         = r_done0;
    assign arb.done1         = r_done1;
    assign arb.data_out      = r_data;
    assign arb.hit_miss_out  = r_hit;
    assign arb.l2_vector_out = r_l2_vector;
endmodule
`default_nettype wire

// File: tb/tb_l2_access_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_l2_access_arbiter
//  Purpose  : Self-checking bench for l2_access_arbiter against a transaction model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_l2_access_arbiter;
    localparam int TAG_W = 4;
    localparam int DAT_W = 4;
    localparam int OP_W  = 2;
    localparam int LAT   = 2;
    localparam int LINE  = OP_W + TAG_W + DAT_W;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    l2_access_arbiter_if #(.CACHE_TAG_WIDTH(TAG_W), .CACHE_DATA_WIDTH(DAT_W),
                           .OPCODE_WIDTH(OP_W)) bus ();

    l2_access_arbiter #(
        .CACHE_TAG_WIDTH (TAG_W),
        .CACHE_DATA_WIDTH(DAT_W),
        .OPCODE_WIDTH    (OP_W),
        .L2_LATENCY      (LAT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .arb  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Transaction-level reference: each grant is a record with grant edge,
    // done edge and the vector captured at grant.
    int              k = 0;
    bit              m_active = 1'b0;
    bit              m_gid = 1'b0;
    bit              m_valid = 1'b0;
    logic [LINE-1:0] m_vec = '0;
    int              m_g = 0;
    int              m_d = 0;
    int              m_free = 0;
    bit              m_ptr = 1'b0;
    logic [DAT_W-1:0] m_data = '0;
    bit              m_hit = 1'b0;

    bit rec = 1'b0;
    int done_ids[$];
    int done_edges[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, k);
        end
    endtask

    task automatic model_edge(input bit rn, input bit r0, input bit r1,
                              input logic [LINE-1:0] v0, input logic [LINE-1:0] v1,
                              input logic [DAT_W-1:0] d, input bit h);
        logic [OP_W-1:0] op;
        if (!rn) begin
            m_active = 1'b0;
            m_ptr    = 1'b0;
            m_data   = '0;
            m_hit    = 1'b0;
            m_free   = k + 1;
        end else begin
            if (m_active && k == m_d + 1) begin
                m_active = 1'b0;
                m_ptr    = !m_gid;
            end
            if (!m_active && k >= m_free && (r0 || r1)) begin
                m_gid    = (r0 && r1) ? m_ptr : r1;
                m_vec    = m_gid ? v1 : v0;
                op       = m_vec[LINE-1 -: OP_W];
                m_valid  = (op == 2'b01) || (op == 2'b10);
                m_g      = k;
                m_d      = m_valid ? k + LAT : k;
                m_free   = m_d + 2;
                m_active = 1'b1;
            end
            if (m_active && k == m_d) begin
                m_data = m_valid ? d : '0;
                m_hit  = m_valid ? h : 1'b0;
            end
        end
    endtask

    task automatic cyc(input bit rn, input bit r0, input bit r1,
                       input logic [LINE-1:0] v0, input logic [LINE-1:0] v1,
                       input logic [DAT_W-1:0] d, input bit h);
        logic [LINE-1:0] exp_vec;
        rst_n              = rn;
        bus.req0           = r0;
        bus.req1           = r1;
        bus.vector0_in     = v0;
        bus.vector1_in     = v1;
        bus.l2_data_in     = d;
        bus.l2_hit_miss_in = h;
        @(posedge clk);
        k++;
        model_edge(rn, r0, r1, v0, v1, d, h);
        #1;
        exp_vec = (m_active && m_valid && k < m_g + LAT) ? m_vec : '0;
        check_val("busy0", bus.busy0, m_active && !m_gid);
        check_val("busy1", bus.busy1, m_active && m_gid);
        check_val("done0", bus.done0, m_active && k == m_d && !m_gid);
        check_val("done1", bus.done1, m_active && k == m_d && m_gid);
        check_val("data_out", bus.data_out, m_data);
        check_val("hit_miss_out", bus.hit_miss_out, m_hit);
        check_val("l2_vector_out", bus.l2_vector_out, exp_vec);
        if (rec) begin
            if (bus.done0) begin done_ids.push_back(0); done_edges.push_back(k); end
            if (bus.done1) begin done_ids.push_back(1); done_edges.push_back(k); end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, '0, '0, 4'($urandom), 1'($urandom));
    endtask

    initial begin
        logic [LINE-1:0] rv0;
        logic [LINE-1:0] rv1;
        bit q0;
        bit q1;

        // Reset state
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        check_val("reset_vec", bus.l2_vector_out, 10'b0);

        // Read hit on requester 0
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 10'b01_1100_1010, '0, 4'b1010, 1'b1);
        check_val("t1_done0", bus.done0, 1'b1);
        check_val("t1_data", bus.data_out, 4'b1010);
        check_val("t1_hit", bus.hit_miss_out, 1'b1);
        idle(2);

        // Simultaneous requests from a fresh pointer
        cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        rec = 1'b1;
        for (int i = 0; i < 12; i++)
            cyc(1'b1, 1'b1, 1'b1, {2'b01, 8'($urandom)}, {2'b10, 8'($urandom)}, 4'($urandom), 1'($urandom));
        rec = 1'b0;
        check_val("rr_count", done_ids.size(), 3);
        if (done_ids.size() == 3) begin
            check_val("rr_first", done_ids[0], 0);
            check_val("rr_second", done_ids[1], 1);
            check_val("rr_third", done_ids[2], 0);
            check_val("rr_gap1", done_edges[1] - done_edges[0], 4);
            check_val("rr_gap2", done_edges[2] - done_edges[1], 4);
        end
        idle(2);

        // Read miss on requester 1, then data held
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, '0, 10'b01_0101_0000, 4'b0110, 1'b0);
        check_val("t3_done1", bus.done1, 1'b1);
        check_val("t3_miss", bus.hit_miss_out, 1'b0);
        idle(3);
        check_val("t3_hold", bus.data_out, 4'b0110);

        // Invalid opcode: answered without L2
        cyc(1'b1, 1'b1, 1'b0, 10'b00_1111_1111, '0, 4'b1111, 1'b1);
        check_val("t4_done0", bus.done0, 1'b1);
        check_val("t4_vec", bus.l2_vector_out, 10'b0);
        check_val("t4_data", bus.data_out, 4'b0000);
        idle(2);

        // Reset during WAIT, then requester 1 served
        cyc(1'b1, 1'b0, 1'b1, '0, 10'b10_0011_0100, 4'b1001, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, '0, 10'b10_0011_0100, 4'b1001, 1'b1);
        check_val("t5_busy1", bus.busy1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, '0, 10'b01_0011_0100, 4'b0101, 1'b1);
        check_val("t5_done1", bus.done1, 1'b1);
        idle(2);

        // Requester 0 drops req right after grant; pointer then favours 1
        cyc(1'b1, 1'b1, 1'b0, 10'b01_1010_0001, '0, 4'b0011, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, '0, '0, 4'b0011, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, '0, '0, 4'b0011, 1'b1);
        check_val("t6_done0", bus.done0, 1'b1);
        idle(1);
        cyc(1'b1, 1'b1, 1'b1, 10'b01_0000_0001, 10'b01_0000_0010, 4'b0000, 1'b0);
        check_val("t6_ptr", bus.busy1, 1'b1);
        idle(4);

        // Random traffic with occasional resets
        q0 = 1'b0;
        q1 = 1'b0;
        for (int i = 0; i < 600; i++) begin
            q0  = q0 ? ($urandom_range(0, 99) < 85) : ($urandom_range(0, 99) < 40);
            q1  = q1 ? ($urandom_range(0, 99) < 85) : ($urandom_range(0, 99) < 40);
            rv0 = LINE'($urandom);
            rv1 = LINE'($urandom);
            cyc(($urandom_range(0, 99) >= 2), q0, q1, rv0, rv1, 4'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
